conv_window_fetch: RTL

- Feeder for the 3x3 convolution core: walks every pixel of a matrix×matrix feature map held in single-port RAM.
- For each pixel it gathers the 9 neighbourhood values and presents them with position index i and edge code prov.
- It then pulses conv_en for one cycle.
- It is the producing end of the conv core's pixel interface and drives that core's pixel, i, prov and conv_en inputs directly.

---
 rtl/conv_window_fetch.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/conv_window_fetch.sv
// conv_window_fetch: pixel feeder for the 3x3 convolution core.
//
// Walks every pixel of a matrix x matrix feature map stored in single-port
// RAM. For each pixel it reads the 9-point neighbourhood, one slot per cycle,
// and then presents the values on p1..p9 with the position index i and the
// edge code prov. It then strobes conv_en for one cycle. Neighbours that fall
// outside the map are not read and present as zero.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start              one-cycle pulse, begins a pass when idle
//   matrix, matrix2    map side length and map area (matrix*matrix)
//   base_addr          RAM address of pixel 0
//   hold               downstream busy, stalls emission
//   mem_re, mem_addr   RAM read request
//   mem_rdata          RAM read data, valid one cycle after mem_re
//   p1..p9             center, right, left, downleft, upright, down, up,
//                      downright, upleft
//   i, prov            pixel index and edge code (10 right, 11 left, 00 other)
//   conv_en            one-cycle strobe, p1..p9/i/prov valid
//   busy, done         pass in progress / one-cycle end-of-pass pulse
module conv_window_fetch #(
  parameter int SIZE   = 23,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        matrix,
  input  logic [9:0]        matrix2,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              hold,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [SIZE-1:0]   mem_rdata,
  output logic [SIZE-1:0]   p1,
  output logic [SIZE-1:0]   p2,
  output logic [SIZE-1:0]   p3,
  output logic [SIZE-1:0]   p4,
  output logic [SIZE-1:0]   p5,
  output logic [SIZE-1:0]   p6,
  output logic [SIZE-1:0]   p7,
  output logic [SIZE-1:0]   p8,
  output logic [SIZE-1:0]   p9,
  output logic [9:0]        i,
  output logic [1:0]        prov,
  output logic              conv_en,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_EMIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        slot_q, slot_d;
  logic [9:0]        i_q, i_d;
  logic [4:0]        col_q, col_d;
  logic [1:0]        prov_q, prov_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q;

  // A read issued in slot k lands one cycle later; remember which slot
  // and whether it was actually read so the right register loads.
  logic              pend_q;
  logic [3:0]        pend_slot_q;
  logic              pend_rd_q;
  logic [SIZE-1:0]   p_q [9];

  // Neighbour validity, derived from i and the running column counter.
  logic [9:0] matrix_w;
  logic       up_ok, down_ok, left_ok, last_col;
  assign matrix_w = {5'd0, matrix};
  assign up_ok    = i_q >= matrix_w;
  assign down_ok  = i_q < (matrix2 - matrix_w);
  assign left_ok  = col_q != 5'd0;
  assign last_col = col_q == (matrix - 5'd1);

  logic              slot_ok;
  logic [9:0]        slot_off;
  logic [ADDR_W-1:0] slot_addr;

  // NOTE: every signal assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    slot_ok  = 1'b0;
    slot_off = i_q;
    case (slot_q)
      4'd0: begin slot_ok = 1'b1;                slot_off = i_q;                   end
      4'd1: begin slot_ok = !last_col;           slot_off = i_q + 10'd1;           end
      4'd2: begin slot_ok = left_ok;             slot_off = i_q - 10'd1;           end
      4'd3: begin slot_ok = down_ok && left_ok;  slot_off = i_q + matrix_w - 10'd1; end
      4'd4: begin slot_ok = up_ok && !last_col;  slot_off = i_q - matrix_w + 10'd1; end
      4'd5: begin slot_ok = down_ok;             slot_off = i_q + matrix_w;        end
      4'd6: begin slot_ok = up_ok;               slot_off = i_q - matrix_w;        end
      4'd7: begin slot_ok = down_ok && !last_col; slot_off = i_q + matrix_w + 10'd1; end
      4'd8: begin slot_ok = up_ok && left_ok;    slot_off = i_q - matrix_w - 10'd1; end
      default: begin slot_ok = 1'b0;             slot_off = i_q;                   end
    endcase
  end

  assign slot_addr = base_addr + ADDR_W'(slot_off);
  assign mem_re    = (state_q == S_FETCH) && slot_ok;
  // A skipped slot leaves the address bus where it was.
  assign mem_addr  = mem_re ? slot_addr : mem_addr_q;

  // Column advance with wrap at the row end; prov follows the new column.
  logic [4:0] col_next;
  assign col_next = last_col ? 5'd0 : col_q + 5'd1;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    i_d     = i_q;
    col_d   = col_q;
    prov_d  = prov_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DONE;
          if (matrix >= 5'd2) begin
            state_d = S_FETCH;
            slot_d  = 4'd0;
            i_d     = 10'd0;
            col_d   = 5'd0;
            prov_d  = 2'b11;
            busy_d  = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (slot_q == 4'd8) state_d = S_DRAIN;
        else                slot_d  = slot_q + 4'd1;
      end
      S_DRAIN: state_d = S_EMIT;
      S_EMIT: begin
        if (!hold) begin
          if (i_q == matrix2 - 10'd1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            slot_d  = 4'd0;
            i_d     = i_q + 10'd1;
            col_d   = col_next;
            if (col_next == matrix - 5'd1) prov_d = 2'b10;
            else if (col_next == 5'd0)     prov_d = 2'b11;
            else                           prov_d = 2'b00;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs as they were before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      slot_q      <= 4'd0;
      i_q         <= 10'd0;
      col_q       <= 5'd0;
      prov_q      <= 2'b00;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      pend_q      <= 1'b0;
      pend_slot_q <= 4'd0;
      pend_rd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      i_q         <= i_d;
      col_q       <= col_d;
      prov_q      <= prov_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr;
      pend_q      <= (state_q == S_FETCH);
      pend_slot_q <= slot_q;
      pend_rd_q   <= mem_re;
    end
  end

  // NOTE: the nine neighbourhood registers are flops, not a RAM, so they
  // take the reset like any other state and come up as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) p_q[k] <= '0;
    end else if (pend_q) begin
      for (int k = 0; k < 9; k++)
        if (pend_slot_q == 4'(k)) p_q[k] <= pend_rd_q ? mem_rdata : '0;
    end
  end

  assign p1      = p_q[0];
  assign p2      = p_q[1];
  assign p3      = p_q[2];
  assign p4      = p_q[3];
  assign p5      = p_q[4];
  assign p6      = p_q[5];
  assign p7      = p_q[6];
  assign p8      = p_q[7];
  assign p9      = p_q[8];
  assign i       = i_q;
  assign prov    = prov_q;
  assign conv_en = (state_q == S_EMIT) && !hold;
  assign busy    = busy_q;
  assign done    = (state_q == S_DONE);

endmodule
